// File: rtl/fp_sqrt_unit_pkg.sv
// Shared widths, bias constants, state codes and packed formats for the norm square-root stage.
package fp_sqrt_unit_pkg;

  localparam int SUMSQ_EXP_W = 9;
  localparam int SUMSQ_MAN_W = 30;
  localparam int NORM_EXP_W  = 8;
  localparam int NORM_FRAC_W = 15;

  localparam int SUMSQ_BIAS = 254;
  localparam int NORM_BIAS  = 127;

  localparam int RAD_W  = 32;
  localparam int ROOT_W = 16;
  localparam int REM_W  = 18;
  localparam int EXP_W  = 11;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_ROOT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [SUMSQ_EXP_W-1:0] expo;
    logic [SUMSQ_MAN_W-1:0] mant;
  } sum_sq_t;

  typedef struct packed {
    logic                   sign;
    logic [NORM_EXP_W-1:0]  expo;
    logic [NORM_FRAC_W-1:0] frac;
  } norm_t;

endpackage

// File: rtl/fp_sqrt_core.sv
// Restoring integer square root of a 32-bit radicand, one root bit per cycle, MSB first.
// done is high during the final iteration; root holds the full result from the next cycle on.
module fp_sqrt_core
  import fp_sqrt_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAD_W-1:0]  x,
  output logic [ROOT_W-1:0] root,
  output logic              busy,
  output logic              done
);

  logic [RAD_W-1:0] x_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W+1:0] cur;
  logic [REM_W+1:0] div;
  logic [REM_W-1:0] rem_nx;
  logic             take;

  always_comb begin
    cur    = {rem_q, x_q[RAD_W-1 -: 2]};
    div    = {2'b00, root, 2'b01};
    take   = (cur >= div);
    // A failed trial leaves cur below 4Q+1, so it always fits the remainder width.
    rem_nx = take ? REM_W'(cur - div) : cur[REM_W-1:0];
  end

  assign done = busy && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      root  <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      x_q   <= x;
      rem_q <= '0;
      cnt_q <= CNT_W'(ROOT_W - 1);
      root  <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      x_q   <= {x_q[RAD_W-3:0], 2'b00};
      rem_q <= rem_nx;
      root  <= {root[ROOT_W-2:0], take};
      if (cnt_q == '0) begin
        busy <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_unit.sv
// Square root of a sum-of-squares word into the 24-bit norm format; owns handshake,
// mantissa normalisation and exponent, and hands the integer root to fp_sqrt_core.
module fp_sqrt_unit
  import fp_sqrt_unit_pkg::*;
#(
  parameter int IN_EXP_W  = SUMSQ_EXP_W,
  parameter int IN_MAN_W  = SUMSQ_MAN_W,
  parameter int OUT_EXP_W = NORM_EXP_W,
  parameter int OUT_MAN_W = NORM_FRAC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_EXP_W+IN_MAN_W-1:0]   sum_sq,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_EXP_W+OUT_MAN_W:0]   norm,
  output logic                           underflow
);

  logic [1:0]              state;
  logic [RAD_W-1:0]        w;
  logic signed [EXP_W-1:0] e;
  logic signed [EXP_W-1:0] exp_out;
  logic                    zero;
  logic                    norm_ok;
  logic                    core_start;
  logic                    core_busy;
  logic                    core_done;
  logic [ROOT_W-1:0]       root;
  sum_sq_t                 op;
  norm_t                   res;
  logic                    uf;

  assign op = sum_sq;

  // Normalised once the radicand sits in [2^28, 2^30): the root then lands in [1, 2).
  assign norm_ok    = (w[31:28] != 4'd0) && (w[31:30] == 2'd0);
  assign core_start = (state == ST_NORM) && norm_ok;

  // E is even here; halving it and removing half the input bias plus the output bias
  // re-biases the exponent (the two offsets cancel for 254/127).
  assign exp_out = (e >>> 1) - EXP_W'(SUMSQ_BIAS / 2 - NORM_BIAS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      w     <= '0;
      e     <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (op.mant == '0) begin
              zero  <= 1'b1;
              state <= ST_DONE;
            end else begin
              zero  <= 1'b0;
              state <= ST_NORM;
              if (op.expo[0]) begin
                w <= {1'b0, op.mant, 1'b0};
                e <= {2'b00, op.expo} - 11'd1;
              end else begin
                w <= {2'b00, op.mant};
                e <= {2'b00, op.expo};
              end
            end
          end
        end
        ST_NORM: begin
          if (w[31:28] == 4'd0) begin
            w <= {w[29:0], 2'b00};
            e <= e - 11'sd2;
          end else if (w[31:30] != 2'd0) begin
            w <= {2'b00, w[31:2]};
            e <= e + 11'sd2;
          end else begin
            state <= ST_ROOT;
          end
        end
        ST_ROOT: begin
          if (core_done) begin
            state <= ST_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  fp_sqrt_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .x     ({w[29:0], 2'b00}),
    .root  (root),
    .busy  (core_busy),
    .done  (core_done)
  );

  always_comb begin
    res = '0;
    uf  = 1'b0;
    if (state == ST_DONE && !zero) begin
      if (exp_out[EXP_W-1] || exp_out == '0) begin
        uf = 1'b1;
      end else begin
        res.sign = 1'b0;
        res.expo = exp_out[7:0];
        res.frac = root[14:0];
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign norm      = res;
  assign underflow = uf;

  // A normalised radicand always yields a root with its top bit set.
  assert property (@(posedge clk) disable iff (rst)
                   (state == ST_DONE && !zero) |-> root[ROOT_W-1]);

  // The core is only started from NORM, so it can never be busy while the wrapper is idle.
  assert property (@(posedge clk) disable iff (rst)
                   (state == ST_IDLE) |-> !core_busy);

endmodule

// File: tb/tb_fp_sqrt_unit.sv
// Randomised and directed checks of fp_sqrt_unit against a real-arithmetic square-root model.
module tb_fp_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] sum_sq;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] norm;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;

  fp_sqrt_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_sq    (sum_sq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm      (norm),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Returns {underflow, norm}: true root by real arithmetic, truncated to 15 fraction bits.
  function automatic logic [24:0] ref_sqrt(input logic [8:0] ex, input logic [29:0] m);
    real v;
    real r;
    int  sc;
    int  k;
    int  fr;
    logic [24:0] o;
    o = '0;
    if (m != 0) begin
      v  = m;
      sc = int'(ex) - 254 - 28;
      for (int i = 0; i < sc; i++) v = v * 2.0;
      for (int i = 0; i < -sc; i++) v = v * 0.5;
      r = $sqrt(v);
      k = 0;
      while (r >= 2.0) begin r = r / 2.0; k++; end
      while (r < 1.0) begin r = r * 2.0; k--; end
      k = k + 127;
      if (k <= 0) begin
        o[24] = 1'b1;
      end else begin
        fr = int'($floor((r - 1.0) * 32768.0));
        o  = {1'b0, 1'b0, k[7:0], fr[14:0]};
      end
    end
    return o;
  endfunction

  // exp_lat 0: only a plausibility range; exp_norm -1: take the model's value.
  task automatic run_op(input string tag, input logic [8:0] ex, input logic [29:0] m,
                        input int hold, input int exp_lat, input int exp_norm);
    logic [24:0] ref_v;
    logic [23:0] seen;
    int lat;
    ref_v = ref_sqrt(ex, m);
    if (exp_norm >= 0) ref_v[23:0] = exp_norm[23:0];
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    sum_sq   = {ex, m};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".norm"}, 32'(norm), 32'(ref_v[23:0]));
    check({tag, ".underflow"}, 32'(underflow), 32'(ref_v[24]));
    if (exp_lat > 0) check({tag, ".latency"}, lat, exp_lat);
    else if (m == 0) check({tag, ".latency"}, lat, 1);
    else check({tag, ".latency_range"}, 32'(lat >= 18 && lat <= 33), 32'd1);
    seen = norm;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      sum_sq   = {9'(254), 30'h1000_0000};
      @(posedge clk); #1;
      check({tag, ".hold_norm"}, 32'(norm), 32'(seen));
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rv;
    logic [29:0] m;
    logic [8:0]  ex;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_sq    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.norm", 32'(norm), 32'd0);
    check("reset.underflow", 32'(underflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("one",     9'd254, 30'h1000_0000, 0, 18, 24'h3F8000);
    run_op("four",    9'd255, 30'h2000_0000, 0, 19, 24'h400000);
    run_op("two",     9'd254, 30'h2000_0000, 0, 18, 24'h3FB504);
    run_op("quarter", 9'd254, 30'h0400_0000, 0, 19, 24'h3F0000);
    run_op("zero",    9'd77,  30'h0,         0, 1,  24'h0);
    run_op("uflow",   9'd1,   30'h1000_0000, 5, 18, 24'h0);

    // Abort an operation in the middle of the root iterations.
    sum_sq   = {9'd200, 30'h3FFF_FFFF};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_abort", 9'd254, 30'h1000_0000, 0, 18, 24'h3F8000);

    for (int t = 0; t < 40; t++) begin
      rv = $urandom;
      m  = rv[29:0] >> $urandom_range(0, 29);
      if ($urandom_range(0, 9) == 0) m = '0;
      ex = 9'($urandom_range(0, 508));
      run_op("rand", ex, m, $urandom_range(0, 2), 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
